salida_pwm: RTL and testbench

SALIDA_PWM -- requirements
Module: salida_pwm

---
 rtl/servo_pkg.sv | 20 ++
 rtl/contador_pwm.sv | 38 +++
 rtl/salida_pwm.sv | 120 ++++++++++++
 tb/tb_salida_pwm.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared servo constants: default control-word format, saturation limits and PWM period.
package servo_pkg;

  localparam int MAGNITUD_DEF = 17;
  localparam int DECIMAL_DEF  = 0;
  localparam int N_DEF        = MAGNITUD_DEF + DECIMAL_DEF + 1;
  localparam int PERIODO_DEF  = 1000;

  function automatic longint lim_max(input int n);
    return (longint'(1) <<< (n - 1)) - 1;
  endfunction

  function automatic longint lim_min(input int n);
    return -(longint'(1) <<< (n - 1));
  endfunction

  localparam longint MAX_N = lim_max(N_DEF);
  localparam longint MIN_N = lim_min(N_DEF);

endpackage

// File: rtl/contador_pwm.sv
// PWM period counter (0..PERIODO-1) with registered duty comparator.
module contador_pwm #(
  parameter int PERIODO = 1000,
  parameter int W       = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] duty,
  output logic [W-1:0] counter,
  output logic         wrap,
  output logic         pwm
);

  localparam logic [W-1:0] ULTIMO = W'(PERIODO - 1);

  logic [W-1:0] counter_q, counter_d;
  logic         pwm_q, pwm_d;

  always_comb begin
    counter_d = (counter_q == ULTIMO) ? '0 : counter_q + 1'b1;
    pwm_d     = (counter_q < duty);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      counter_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      pwm_q     <= pwm_d;
    end
  end

  assign counter = counter_q;
  assign wrap    = (counter_q == ULTIMO);
  assign pwm     = pwm_q;

endmodule

// File: rtl/salida_pwm.sv
// Servo PWM output stage: saturating PID sum, magnitude/sign clamp, period-aligned duty update.
// Optional deadband on the clamped magnitude is enabled with macro SALIDA_PWM_DEADBAND_EN.
module salida_pwm
  import servo_pkg::*;
#(
  parameter int Magnitud    = MAGNITUD_DEF,
  parameter int Decimal     = DECIMAL_DEF,
  parameter int N           = Magnitud + Decimal + 1,
  parameter int PERIODO     = PERIODO_DEF,
  parameter int ZONA_MUERTA = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] p_term,
  input  logic [N-1:0] i_term,
  input  logic [N-1:0] d_term,
  output logic         pwm,
  output logic         dir,
  output logic [N-1:0] duty,
  output logic         saturado,
  output logic         inicio_periodo
);

  localparam logic signed [N+1:0] SAT_MAX = (N+2)'(lim_max(N));
  localparam logic signed [N+1:0] SAT_MIN = (N+2)'(lim_min(N));
  localparam logic        [N-1:0] CLAMP   = N'(PERIODO - 1);

  if (PERIODO < 2 || ZONA_MUERTA < 0) begin : g_param_invalid
    $error("salida_pwm: PERIODO must be >= 2 and ZONA_MUERTA >= 0");
  end

  logic signed [N+1:0] suma;
  logic signed [N-1:0] u_reg_q, u_reg_d;
  logic                saturado_q, saturado_d;
  logic signed [N:0]   u_ext;
  logic        [N:0]   magnitud;
  logic        [N-1:0] mag_clamp;
  logic        [N-1:0] pendiente_q, pendiente_d;
  logic                sign_pend_q, sign_pend_d;
  logic        [N-1:0] duty_q, duty_d;
  logic                dir_q, dir_d;
  logic        [N-1:0] counter;
  logic                wrap;

  // N+2 bits hold the sum of three N-bit terms without overflow before clipping.
  always_comb begin
    suma = $signed({{2{p_term[N-1]}}, p_term})
         + $signed({{2{i_term[N-1]}}, i_term})
         + $signed({{2{d_term[N-1]}}, d_term});
    u_reg_d    = u_reg_q;
    saturado_d = saturado_q;
    if (enable) begin
      if (suma > SAT_MAX) begin
        u_reg_d    = SAT_MAX[N-1:0];
        saturado_d = 1'b1;
      end else if (suma < SAT_MIN) begin
        u_reg_d    = SAT_MIN[N-1:0];
        saturado_d = 1'b1;
      end else begin
        u_reg_d    = suma[N-1:0];
        saturado_d = 1'b0;
      end
    end
  end

  // One extra bit lets the most negative word negate cleanly before clamping.
  always_comb begin
    u_ext       = {u_reg_q[N-1], u_reg_q};
    magnitud    = u_ext[N] ? $unsigned(-u_ext) : $unsigned(u_ext);
    mag_clamp   = (magnitud > {1'b0, CLAMP}) ? CLAMP : magnitud[N-1:0];
    pendiente_d = mag_clamp;
    sign_pend_d = u_reg_q[N-1];
`ifdef SALIDA_PWM_DEADBAND_EN
    if (mag_clamp < N'(ZONA_MUERTA)) begin
      pendiente_d = '0;
      sign_pend_d = 1'b0;
    end
`endif
    duty_d = wrap ? pendiente_q : duty_q;
    dir_d  = wrap ? sign_pend_q : dir_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      u_reg_q     <= '0;
      saturado_q  <= 1'b0;
      pendiente_q <= '0;
      sign_pend_q <= 1'b0;
      duty_q      <= '0;
      dir_q       <= 1'b0;
    end else begin
      u_reg_q     <= u_reg_d;
      saturado_q  <= saturado_d;
      pendiente_q <= pendiente_d;
      sign_pend_q <= sign_pend_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
    end
  end

  contador_pwm #(
    .PERIODO (PERIODO),
    .W       (N)
  ) u_contador (
    .clk     (clk),
    .reset   (reset),
    .duty    (duty_q),
    .counter (counter),
    .wrap    (wrap),
    .pwm     (pwm)
  );

  // Gated by reset so the flag reads low while held in reset, high on the first free-running cycle.
  assign inicio_periodo = (counter == '0) & reset;
  assign duty           = duty_q;
  assign dir            = dir_q;
  assign saturado       = saturado_q;

endmodule

// File: tb/tb_salida_pwm.sv
// Directed self-checking bench for salida_pwm (N=18, PERIODO=1000).
module tb_salida_pwm;

  localparam int N       = 18;
  localparam int PERIODO = 1000;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] p_term, i_term, d_term;
  logic         pwm, dir, saturado, inicio_periodo;
  logic [N-1:0] duty;

  int checks = 0;
  int errors = 0;
  int highs;

  always #5 clk = ~clk;

  salida_pwm #(
    .Magnitud    (17),
    .Decimal     (0),
    .N           (N),
    .PERIODO     (PERIODO),
    .ZONA_MUERTA (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .p_term         (p_term),
    .i_term         (i_term),
    .d_term         (d_term),
    .pwm            (pwm),
    .dir            (dir),
    .duty           (duty),
    .saturado       (saturado),
    .inicio_periodo (inicio_periodo)
  );

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input longint p, input longint i, input longint d);
    @(negedge clk);
    p_term = N'(p);
    i_term = N'(i);
    d_term = N'(d);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic waitInicio(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!inicio_periodo && n < 2 * PERIODO) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_wrap_seen"}, longint'(inicio_periodo), 1);
  endtask

  task automatic measurePeriod(output int h);
    h = 0;
    for (int k = 0; k < PERIODO; k++) begin
      if (pwm) h++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    p_term = '0;
    i_term = '0;
    d_term = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pwm", pwm, 0);
    checkOutput("rst_duty", duty, 0);
    checkOutput("rst_dir", dir, 0);
    checkOutput("rst_sat", saturado, 0);
    checkOutput("rst_inicio", inicio_periodo, 0);
    checkOutput("rst_u", $signed(dut.u_reg_q), 0);
    checkOutput("rst_pend", dut.pendiente_q, 0);
    reset = 1'b1;
    #1;
    checkOutput("rel_inicio", inicio_periodo, 1);
    checkOutput("rel_counter", dut.counter, 0);
    @(negedge clk);
    checkOutput("rel_counter_next", dut.counter, 1);
    checkOutput("rel_inicio_next", inicio_periodo, 0);

    // basic positive command and stage latency
    applyStimulus(100, 0, 50);
    checkOutput("t1_u", $signed(dut.u_reg_q), 150);
    checkOutput("t1_pend_early", dut.pendiente_q, 0);
    @(negedge clk);
    checkOutput("t1_pend", dut.pendiente_q, 150);
    checkOutput("t1_duty_before_wrap", duty, 0);
    waitInicio("t1");
    checkOutput("t1_duty", duty, 150);
    checkOutput("t1_dir", dir, 0);
    measurePeriod(highs);
    checkOutput("t1_highs", highs, 150);

    // negative command
    applyStimulus(-300, -20, 0);
    @(negedge clk);
    checkOutput("t2_sat", saturado, 0);
    checkOutput("t2_pend", dut.pendiente_q, 320);
    checkOutput("t2_sign", dut.sign_pend_q, 1);
    waitInicio("t2");
    checkOutput("t2_duty", duty, 320);
    checkOutput("t2_dir", dir, 1);
    measurePeriod(highs);
    checkOutput("t2_highs", highs, 320);

    // positive saturation
    applyStimulus(131071, 131071, 0);
    checkOutput("t3_u", $signed(dut.u_reg_q), 131071);
    checkOutput("t3_sat", saturado, 1);
    waitInicio("t3");
    checkOutput("t3_duty", duty, 999);
    checkOutput("t3_dir", dir, 0);
    measurePeriod(highs);
    checkOutput("t3_highs", highs, 999);

    // negative saturation, most negative word
    applyStimulus(-131072, -131072, -131072);
    checkOutput("t4_u", $signed(dut.u_reg_q), -131072);
    checkOutput("t4_sat", saturado, 1);
    @(negedge clk);
    checkOutput("t4_pend", dut.pendiente_q, 999);
    waitInicio("t4");
    checkOutput("t4_duty", duty, 999);
    checkOutput("t4_dir", dir, 1);

    // enable in the wrap cycle
    applyStimulus(200, 0, 0);
    checkOutput("t5_sat_clear", saturado, 0);
    waitInicio("t5a");
    checkOutput("t5_duty_old", duty, 200);
    repeat (PERIODO - 1) @(negedge clk);
    checkOutput("t5_counter_last", dut.counter, PERIODO - 1);
    p_term = N'(500);
    i_term = '0;
    d_term = '0;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    checkOutput("t5_duty_this", duty, 200);
    checkOutput("t5_u", $signed(dut.u_reg_q), 500);
    @(negedge clk);
    checkOutput("t5_pend", dut.pendiente_q, 500);
    checkOutput("t5_duty_still", duty, 200);
    waitInicio("t5b");
    checkOutput("t5_duty_next", duty, 500);

    // reset mid-period
    repeat (400) @(negedge clk);
    checkOutput("t6_counter", dut.counter, 400);
    checkOutput("t6_pwm_high", pwm, 1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_pwm", pwm, 0);
    checkOutput("t6_duty", duty, 0);
    checkOutput("t6_counter0", dut.counter, 0);
    checkOutput("t6_pend", dut.pendiente_q, 0);
    reset = 1'b1;
    #1;
    checkOutput("t6_inicio", inicio_periodo, 1);

    // small commands around the deadband threshold
    applyStimulus(3, 0, 0);
    waitInicio("t7a");
`ifdef SALIDA_PWM_DEADBAND_EN
    checkOutput("t7_duty3", duty, 0);
    measurePeriod(highs);
    checkOutput("t7_highs3", highs, 0);
`else
    checkOutput("t7_duty3", duty, 3);
    measurePeriod(highs);
    checkOutput("t7_highs3", highs, 3);
`endif
    applyStimulus(-3, 0, 0);
    waitInicio("t7b");
`ifdef SALIDA_PWM_DEADBAND_EN
    checkOutput("t7_duty_m3", duty, 0);
    checkOutput("t7_dir_m3", dir, 0);
`else
    checkOutput("t7_duty_m3", duty, 3);
    checkOutput("t7_dir_m3", dir, 1);
`endif
    applyStimulus(4, 0, 0);
    waitInicio("t7c");
    checkOutput("t7_duty4", duty, 4);
    checkOutput("t7_dir4", dir, 0);
    measurePeriod(highs);
    checkOutput("t7_highs4", highs, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
